// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

   localparam int unsigned LAT_DEFAULT        = 2;
   localparam int unsigned STARVE_MAX_DEFAULT = 4;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StResp
   } state_e;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } owner_e;

endpackage

// File: rtl/mem_arbiter_lat_timer.sv
// Memory latency countdown: loaded on grant, done on the last WAIT cycle.
module lat_timer
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned LAT = LAT_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic done_o
);

   logic [2:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= 3'd0;
      end else if (load_i) begin
         cnt_q <= 3'(LAT);
      end else if (cnt_q != 3'd0) begin
         cnt_q <= cnt_q - 3'd1;
      end
   end

   // WAIT cycle k (1-based) sees cnt_q == LAT-k+1, so the last one sees 1.
   assign done_o = (cnt_q == 3'd1);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-outstanding memory arbiter with fetch anti-starvation.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned LAT        = LAT_DEFAULT,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST_X,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   state_e      state_q;
   owner_e      owner_q;
   logic        we_q;
   logic [3:0]  starve_q;
   logic [31:0] if_rdata_q;
   logic [31:0] d_rdata_q;
   logic        grant;
   logic        fetch_wins;
   logic        lat_done;

   assign fetch_wins = if_req && (!d_req || (starve_q == 4'(STARVE_MAX)));
   assign grant      = (state_q == StIdle) && (if_req || d_req);
   assign if_gnt     = grant && fetch_wins;
   assign d_gnt      = grant && !fetch_wins;
   assign mem_en     = grant;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_be    = 4'd0;
      if (if_gnt) begin
         mem_addr = if_addr;
         mem_be   = 4'b1111;
      end else if (d_gnt) begin
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_be    = d_be;
      end
   end

   lat_timer #(
      .LAT (LAT)
   ) u_lat_timer (
      .clk_i  (CLK),
      .rst_i  (RST_X),
      .load_i (grant),
      .done_o (lat_done)
   );

   always_ff @(posedge CLK or posedge RST_X) begin
      if (RST_X) begin
         state_q    <= StIdle;
         owner_q    <= OWN_IF;
         we_q       <= 1'b0;
         starve_q   <= 4'd0;
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (grant) begin
                  state_q <= StWait;
                  owner_q <= fetch_wins ? OWN_IF : OWN_D;
                  we_q    <= !fetch_wins && d_we;
                  if (fetch_wins) begin
                     starve_q <= 4'd0;
                  end else if (if_req && (starve_q != 4'(STARVE_MAX))) begin
                     starve_q <= starve_q + 4'd1;
                  end
               end
            end
            StWait: begin
               if (lat_done) begin
                  state_q <= StResp;
                  if (owner_q == OWN_IF) begin
                     if_rdata_q <= mem_rdata;
                  end else begin
                     // Stores complete with zero data rather than whatever the bus returns.
                     d_rdata_q <= we_q ? 32'd0 : mem_rdata;
                  end
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign if_rvalid = (state_q == StResp) && (owner_q == OWN_IF);
   assign d_rvalid  = (state_q == StResp) && (owner_q == OWN_D);
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with LAT=2, STARVE_MAX=4.
module tb_mem_arbiter;

   logic        CLK;
   logic        RST_X;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   mem_arbiter #(
      .LAT        (2),
      .STARVE_MAX (4)
   ) dut (
      .CLK       (CLK),
      .RST_X     (RST_X),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_be      (d_be),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   initial begin
      logic [1:0] exp_gnt;
      RST_X     = 1'b1;
      if_req    = 1'b0;
      if_addr   = 32'd0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = 32'd0;
      d_wdata   = 32'd0;
      d_be      = 4'd0;
      mem_rdata = 32'hFFFF_FFFF;

      mid();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);

      // Fetch read
      next_cycle();
      RST_X   = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h10;
      mid();
      chk("f_if_gnt", 32'(if_gnt), 32'd1);
      chk("f_d_gnt", 32'(d_gnt), 32'd0);
      chk("f_mem_en", 32'(mem_en), 32'd1);
      chk("f_mem_addr", mem_addr, 32'h10);
      chk("f_mem_we", 32'(mem_we), 32'd0);
      chk("f_mem_be", 32'(mem_be), 32'hF);
      chk("f_busy0", 32'(busy), 32'd0);
      next_cycle();
      if_req  = 1'b0;
      if_addr = 32'd0;
      mid();
      chk("f_busy1", 32'(busy), 32'd1);
      chk("f_mem_en1", 32'(mem_en), 32'd0);
      chk("f_rvalid1", 32'(if_rvalid), 32'd0);
      next_cycle();
      mem_rdata = 32'h00A0_0313;
      mid();
      chk("f_busy2", 32'(busy), 32'd1);
      chk("f_rvalid2", 32'(if_rvalid), 32'd0);
      next_cycle();
      mem_rdata = 32'hFFFF_FFFF;
      mid();
      chk("f_rvalid3", 32'(if_rvalid), 32'd1);
      chk("f_rdata3", if_rdata, 32'h00A0_0313);
      chk("f_busy3", 32'(busy), 32'd1);
      chk("f_d_rvalid3", 32'(d_rvalid), 32'd0);
      next_cycle();
      mid();
      chk("f_busy4", 32'(busy), 32'd0);
      chk("f_rvalid4", 32'(if_rvalid), 32'd0);
      chk("f_rdata_hold", if_rdata, 32'h00A0_0313);

      // Store
      next_cycle();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h20;
      d_wdata = 32'hDEAD_BEEF;
      d_be    = 4'b0011;
      mid();
      chk("s_d_gnt", 32'(d_gnt), 32'd1);
      chk("s_if_gnt", 32'(if_gnt), 32'd0);
      chk("s_mem_en", 32'(mem_en), 32'd1);
      chk("s_mem_we", 32'(mem_we), 32'd1);
      chk("s_mem_be", 32'(mem_be), 32'b0011);
      chk("s_mem_addr", mem_addr, 32'h20);
      chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      next_cycle();
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = 32'd0;
      d_wdata   = 32'd0;
      d_be      = 4'd0;
      mem_rdata = 32'h1234_5678;
      mid();
      chk("s_idle_en", 32'(mem_en), 32'd0);
      chk("s_idle_we", 32'(mem_we), 32'd0);
      chk("s_idle_addr", mem_addr, 32'd0);
      chk("s_idle_wdata", mem_wdata, 32'd0);
      chk("s_idle_be", 32'(mem_be), 32'd0);
      next_cycle();
      mid();
      next_cycle();
      mid();
      chk("s_d_rvalid", 32'(d_rvalid), 32'd1);
      chk("s_d_rdata", d_rdata, 32'd0);
      chk("s_if_rdata_hold", if_rdata, 32'h00A0_0313);
      next_cycle();
      mid();

      // Simultaneous requests: data first, fetch at cycle LAT+2
      next_cycle();
      if_req    = 1'b1;
      if_addr   = 32'h40;
      d_req     = 1'b1;
      d_we      = 1'b0;
      d_addr    = 32'h80;
      mem_rdata = 32'hCAFE_F00D;
      mid();
      chk("sim_d_gnt", 32'(d_gnt), 32'd1);
      chk("sim_if_gnt0", 32'(if_gnt), 32'd0);
      next_cycle();
      d_req  = 1'b0;
      d_addr = 32'd0;
      mid();
      chk("sim_if_gnt1", 32'(if_gnt), 32'd0);
      next_cycle();
      mid();
      next_cycle();
      mid();
      chk("sim_d_rvalid", 32'(d_rvalid), 32'd1);
      chk("sim_d_rdata", d_rdata, 32'hCAFE_F00D);
      chk("sim_if_gnt3", 32'(if_gnt), 32'd0);
      next_cycle();
      mid();
      chk("sim_if_gnt4", 32'(if_gnt), 32'd1);
      chk("sim_mem_addr4", mem_addr, 32'h40);
      next_cycle();
      if_req  = 1'b0;
      if_addr = 32'd0;
      mid();
      next_cycle();
      mid();
      next_cycle();
      mid();
      chk("sim_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("sim_if_rdata", if_rdata, 32'hCAFE_F00D);

      // Starvation: D,D,D,D,IF repeating, one grant every LAT+2 cycles
      next_cycle();
      if_req    = 1'b1;
      if_addr   = 32'h200;
      d_req     = 1'b1;
      d_we      = 1'b0;
      d_addr    = 32'h100;
      mem_rdata = 32'h55AA_55AA;
      for (int k = 0; k < 40; k++) begin
         mid();
         if (k % 4 == 0) begin
            exp_gnt = ((k / 4) % 5 == 4) ? 2'b10 : 2'b01;
         end else begin
            exp_gnt = 2'b00;
         end
         chk($sformatf("starve_gnt_c%0d", k), 32'({if_gnt, d_gnt}), 32'(exp_gnt));
         next_cycle();
      end
      // Requests dropped before the grant edge are ignored
      if_req = 1'b0;
      d_req  = 1'b0;
      mid();
      chk("drop_gnt", 32'({if_gnt, d_gnt}), 32'd0);
      chk("drop_busy", 32'(busy), 32'd0);

      // Reset mid-WAIT
      next_cycle();
      if_req  = 1'b1;
      if_addr = 32'h300;
      mid();
      chk("r_if_gnt", 32'(if_gnt), 32'd1);
      next_cycle();
      if_req = 1'b0;
      RST_X  = 1'b1;
      #1;
      chk("r_busy", 32'(busy), 32'd0);
      chk("r_if_rdata", if_rdata, 32'd0);
      chk("r_d_rdata", d_rdata, 32'd0);
      chk("r_mem_en", 32'(mem_en), 32'd0);
      next_cycle();
      mid();
      chk("r_if_rvalid2", 32'(if_rvalid), 32'd0);
      next_cycle();
      mid();
      chk("r_if_rvalid3", 32'(if_rvalid), 32'd0);
      next_cycle();
      RST_X   = 1'b0;
      if_req  = 1'b1;
      if_addr = 32'h400;
      mid();
      chk("r_new_gnt", 32'(if_gnt), 32'd1);
      chk("r_new_addr", mem_addr, 32'h400);
      next_cycle();
      if_req = 1'b0;
      mid();
      chk("r_new_busy", 32'(busy), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
